// File: rtl/stackcalc_cmd_exec_if.sv
// stackcalc_cmd_exec_if: command strobe/code in, stack status out.
interface stackcalc_cmd_exec_if;
    logic       strobe;
    logic [4:0] code;
    logic [7:0] tos;
    logic [3:0] depth;
    logic       err;
    modport master (output strobe, code, input tos, depth, err);
    modport slave (input strobe, code, output tos, depth, err);
endinterface

// File: rtl/stackcalc_cmd_exec.sv
// stackcalc_cmd_exec: strobe-edge driven 8-bit RPN stack calculator with sticky error.
// Define STACKCALC_STRB_SYNC_EN to pass strobe/code through a two-flop synchronizer.
module stackcalc_cmd_exec #(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    stackcalc_cmd_exec_if.slave bus
);
    localparam logic [3:0] FULL     = 4'(DEPTH);
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_DUP   = 4'd6;
    localparam logic [3:0] OP_DROP  = 4'd7;
    localparam logic [3:0] OP_SWAP  = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;

    logic [7:0] stk_q [DEPTH];
    logic [7:0] stk_d [DEPTH];
    logic [7:0] push_s [DEPTH];
    logic [7:0] pop_s [DEPTH];
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d, entry_q, entry_d;
    logic       strobe_q, armed_q, armed_d;
    logic       s_now, idle, fire, binop;
    logic [4:0] c_now;
    logic [3:0] op;
    logic [7:0] alu;

`ifdef STACKCALC_STRB_SYNC_EN
    logic       s1_q, s2_q;
    logic [4:0] c1_q, c2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            c1_q <= '0;
            c2_q <= '0;
        end else begin
            s1_q <= bus.strobe;
            s2_q <= s1_q;
            c1_q <= bus.code;
            c2_q <= c1_q;
        end
    end
    assign s_now = s2_q;
    assign c_now = c2_q;
    assign idle  = ~(bus.strobe | s1_q | s2_q);
`else
    assign s_now = bus.strobe;
    assign c_now = bus.code;
    assign idle  = ~bus.strobe;
`endif

    // A strobe high across reset stays disarmed until the whole path has seen it low.
    assign armed_d = armed_q | idle;
    assign fire    = s_now & ~strobe_q & armed_q;
    assign op      = c_now[3:0];
    assign binop   = (op >= OP_ADD) && (op <= OP_XOR);
    assign alu     = (op == OP_ADD) ? stk_q[1] + stk_q[0] :
                     (op == OP_SUB) ? stk_q[1] - stk_q[0] :
                     (op == OP_AND) ? stk_q[1] & stk_q[0] :
                     (op == OP_OR)  ? stk_q[1] | stk_q[0] : stk_q[1] ^ stk_q[0];

    // Entries at or beyond the count are kept zero, so stk_q[0] reads 0 when empty.
    always_comb begin
        push_s[0] = stk_q[0];
        for (int i = 1; i < DEPTH; i++) push_s[i] = stk_q[i-1];
        for (int i = 0; i < DEPTH - 1; i++) pop_s[i] = stk_q[i+1];
        pop_s[DEPTH-1] = '0;
    end

    always_comb begin
        stk_d   = stk_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        entry_d = entry_q;
        if (fire && c_now[4]) begin
            if (entry_q) stk_d[0] = {stk_q[0][3:0], c_now[3:0]};
            else if (cnt_q == FULL) err_d = 1'b1;
            else begin
                stk_d    = push_s;
                stk_d[0] = {4'h0, c_now[3:0]};
                cnt_d    = cnt_q + 4'd1;
                entry_d  = 1'b1;
            end
        end else if (fire) begin
            entry_d = 1'b0;
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                    if (cnt_q < 4'd2) err_d = 1'b1;
                    else begin
                        stk_d    = pop_s;
                        stk_d[0] = alu;
                        cnt_d    = cnt_q - 4'd1;
                    end
                OP_DUP:
                    if (cnt_q == 4'd0 || cnt_q == FULL) err_d = 1'b1;
                    else begin
                        stk_d = push_s;
                        cnt_d = cnt_q + 4'd1;
                    end
                OP_DROP:
                    if (cnt_q == 4'd0) err_d = 1'b1;
                    else begin
                        stk_d = pop_s;
                        cnt_d = cnt_q - 4'd1;
                    end
                OP_SWAP:
                    if (cnt_q < 4'd2) err_d = 1'b1;
                    else begin
                        stk_d[0] = stk_q[1];
                        stk_d[1] = stk_q[0];
                    end
                OP_CLEAR: begin
                    stk_d = '{default: '0};
                    cnt_d = '0;
                    err_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stk_q    <= '{default: '0};
            cnt_q    <= '0;
            err_q    <= 1'b0;
            entry_q  <= 1'b0;
            strobe_q <= 1'b0;
            armed_q  <= ~bus.strobe;
        end else begin
            stk_q    <= stk_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            entry_q  <= entry_d;
            strobe_q <= s_now;
            armed_q  <= armed_d;
        end
    end

    assign bus.tos   = stk_q[0];
    assign bus.depth = cnt_q;
    assign bus.err   = err_q;
endmodule
